// File: rtl/butterfly_r2_cfg.sv
// Radix-2 DIT butterfly A' = A + W*B, B' = A - W*B with per-transaction inverse/scale,
// output saturation with a sticky overflow flag and a stall-on-backpressure pipeline.
module butterfly_r2_cfg #(
  parameter int unsigned WIDTH    = 16,
  parameter int unsigned TWID_W   = 16,
  parameter int unsigned OUT_W    = WIDTH + 2,
  parameter int unsigned MULT_LAT = 3
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   s_axis_tvalid,
  output logic                   s_axis_tready,
  input  logic                   s_axis_tlast,
  output logic                   m_axis_tvalid,
  input  logic                   m_axis_tready,
  output logic                   m_axis_tlast,
  input  logic [0:3][WIDTH-1:0]  data_i,
  input  logic [0:1][TWID_W-1:0] twiddle_i,
  input  logic                   inv_i,
  input  logic                   scale_i,
  input  logic                   clr_ovf_i,
  output logic [0:3][OUT_W-1:0]  data_o,
  output logic                   ovf_o
);

  localparam int unsigned TW1 = TWID_W + 1;
  localparam int unsigned PW  = WIDTH + TWID_W + 1;
  localparam int unsigned PW1 = PW + 1;
  localparam int unsigned SW  = WIDTH + 2;
  localparam int unsigned SW1 = SW + 1;
  localparam int unsigned LI  = MULT_LAT - 1;

  localparam logic signed [PW:0] RndK = PW1'(1) << (TWID_W - 2);

  if (MULT_LAT < 1 || MULT_LAT > 4) begin : g_bad_mult_lat
    $error("butterfly_r2_cfg: MULT_LAT must be in 1..4");
  end

  // ---------------------------------------------------------------------------
  // Handshake / global enable
  // ---------------------------------------------------------------------------
  logic en;
  logic rdy_q;
  logic accept;
  logic out_vld_q;
  logic out_last_q;
  logic [0:3][OUT_W-1:0] out_data_q;
  logic ovf_q, ovf_d;

  assign en            = !out_vld_q || m_axis_tready;
  assign s_axis_tready = en && rdy_q;
  assign accept        = s_axis_tvalid && s_axis_tready;

  assign m_axis_tvalid = out_vld_q;
  assign m_axis_tlast  = out_last_q;
  assign data_o        = out_data_q;
  assign ovf_o         = ovf_q;

  // ---------------------------------------------------------------------------
  // S0: input register
  // ---------------------------------------------------------------------------
  logic                   s0_vld_q, s0_last_q, s0_inv_q, s0_scale_q;
  logic [0:3][WIDTH-1:0]  s0_data_q;
  logic [0:1][TWID_W-1:0] s0_tw_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdy_q      <= 1'b0;
      s0_vld_q   <= 1'b0;
      s0_last_q  <= 1'b0;
      s0_inv_q   <= 1'b0;
      s0_scale_q <= 1'b0;
      s0_data_q  <= '0;
      s0_tw_q    <= '0;
    end else begin
      rdy_q <= 1'b1;
      if (en) begin
        s0_vld_q   <= accept;
        s0_last_q  <= s_axis_tlast;
        s0_inv_q   <= inv_i;
        s0_scale_q <= scale_i;
        s0_data_q  <= data_i;
        s0_tw_q    <= twiddle_i;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // M1: partial products of B * Wc; conj(W) is formed one bit wider so -min is exact
  // ---------------------------------------------------------------------------
  logic signed [WIDTH-1:0] b_re, b_im;
  logic signed [TWID_W:0]  wc_re, wc_im;
  logic [3:0][PW-1:0]      prod;

  always_comb begin
    b_re  = $signed(s0_data_q[2]);
    b_im  = $signed(s0_data_q[3]);
    wc_re = TW1'($signed(s0_tw_q[0]));
    wc_im = TW1'($signed(s0_tw_q[1]));
    if (s0_inv_q) begin
      wc_im = -wc_im;
    end
    // [0]=Bre*Wre, [1]=Bim*Wim, [2]=Bre*Wim, [3]=Bim*Wre
    prod[0] = PW'(b_re) * PW'(wc_re);
    prod[1] = PW'(b_im) * PW'(wc_im);
    prod[2] = PW'(b_re) * PW'(wc_im);
    prod[3] = PW'(b_im) * PW'(wc_re);
  end

  // M1..M_MULT_LAT: products plus the A operand and sidebands travel together
  logic [MULT_LAT-1:0]                 m_vld_q, m_last_q, m_scale_q;
  logic [MULT_LAT-1:0][3:0][PW-1:0]    m_prod_q;
  logic [MULT_LAT-1:0][1:0][WIDTH-1:0] m_a_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_vld_q   <= '0;
      m_last_q  <= '0;
      m_scale_q <= '0;
      m_prod_q  <= '0;
      m_a_q     <= '0;
    end else if (en) begin
      m_vld_q[0]   <= s0_vld_q;
      m_last_q[0]  <= s0_last_q;
      m_scale_q[0] <= s0_scale_q;
      m_prod_q[0]  <= prod;
      m_a_q[0][0]  <= s0_data_q[0];
      m_a_q[0][1]  <= s0_data_q[1];
      for (int i = 1; i < int'(MULT_LAT); i++) begin
        m_vld_q[i]   <= m_vld_q[i-1];
        m_last_q[i]  <= m_last_q[i-1];
        m_scale_q[i] <= m_scale_q[i-1];
        m_prod_q[i]  <= m_prod_q[i-1];
        m_a_q[i]     <= m_a_q[i-1];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // SA: round W*B back to data scale (half up), then add/subtract
  // ---------------------------------------------------------------------------
  logic signed [PW:0]   p_re_w, p_im_w;
  logic signed [SW-1:0] p_re, p_im, a_re, a_im;
  logic [3:0][SW-1:0]   sa_d;

  always_comb begin
    p_re_w  = PW1'($signed(m_prod_q[LI][0])) - PW1'($signed(m_prod_q[LI][1])) + RndK;
    p_im_w  = PW1'($signed(m_prod_q[LI][2])) + PW1'($signed(m_prod_q[LI][3])) + RndK;
    p_re    = SW'(p_re_w >>> (TWID_W - 1));
    p_im    = SW'(p_im_w >>> (TWID_W - 1));
    a_re    = SW'($signed(m_a_q[LI][0]));
    a_im    = SW'($signed(m_a_q[LI][1]));
    sa_d[0] = a_re + p_re;
    sa_d[1] = a_im + p_im;
    sa_d[2] = a_re - p_re;
    sa_d[3] = a_im - p_im;
  end

  logic               sa_vld_q, sa_last_q, sa_scale_q;
  logic [3:0][SW-1:0] sa_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sa_vld_q   <= 1'b0;
      sa_last_q  <= 1'b0;
      sa_scale_q <= 1'b0;
      sa_q       <= '0;
    end else if (en) begin
      sa_vld_q   <= m_vld_q[LI];
      sa_last_q  <= m_last_q[LI];
      sa_scale_q <= m_scale_q[LI];
      sa_q       <= sa_d;
    end
  end

  // ---------------------------------------------------------------------------
  // SR: optional /2 (round half up), saturate to OUT_W
  // ---------------------------------------------------------------------------
  logic signed [SW:0]    sc [4];
  logic [3:0]            clamp;
  logic [0:3][OUT_W-1:0] data_d;

  always_comb begin
    for (int k = 0; k < 4; k++) begin
      sc[k] = SW1'($signed(sa_q[k]));
      if (sa_scale_q) begin
        sc[k] = (sc[k] + SW1'(1)) >>> 1;
      end
    end
  end

  if (OUT_W < SW) begin : g_sat
    localparam logic signed [SW:0] SatMax = SW1'((1 << (OUT_W - 1)) - 1);
    localparam logic signed [SW:0] SatMin = SW1'(-(1 << (OUT_W - 1)));

    always_comb begin
      clamp  = '0;
      data_d = '0;
      for (int k = 0; k < 4; k++) begin
        data_d[k] = OUT_W'(sc[k]);
        if (sc[k] > SatMax) begin
          data_d[k] = OUT_W'(SatMax);
          clamp[k]  = 1'b1;
        end else if (sc[k] < SatMin) begin
          data_d[k] = OUT_W'(SatMin);
          clamp[k]  = 1'b1;
        end
      end
    end
  end else begin : g_no_sat
    always_comb begin
      clamp  = '0;
      data_d = '0;
      for (int k = 0; k < 4; k++) begin
        data_d[k] = OUT_W'(sc[k]);
      end
    end
  end

  // A set in the same cycle as a clear wins
  always_comb begin
    ovf_d = ovf_q;
    if (en && sa_vld_q && (|clamp)) begin
      ovf_d = 1'b1;
    end else if (clr_ovf_i) begin
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_vld_q  <= 1'b0;
      out_last_q <= 1'b0;
      out_data_q <= '0;
      ovf_q      <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
      if (en) begin
        out_vld_q  <= sa_vld_q;
        out_last_q <= sa_last_q;
        out_data_q <= data_d;
      end
    end
  end

endmodule
